// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/loader requesters, the arbiter and the block RAM port.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  cpu_req;
  logic                  cpu_wen;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_done;
  logic [DATA_WIDTH-1:0] cpu_rdata;

  logic                  ldr_req;
  logic                  ldr_wen;
  logic [ADDR_WIDTH-1:0] ldr_addr;
  logic [DATA_WIDTH-1:0] ldr_wdata;
  logic                  ldr_gnt;
  logic                  ldr_done;
  logic [DATA_WIDTH-1:0] ldr_rdata;

  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_done, cpu_rdata,
    input  ldr_req, ldr_wen, ldr_addr, ldr_wdata,
    output ldr_gnt, ldr_done, ldr_rdata,
    output mem_wen, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output cpu_req, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_done, cpu_rdata,
    output ldr_req, ldr_wen, ldr_addr, ldr_wdata,
    input  ldr_gnt, ldr_done, ldr_rdata,
    input  mem_wen, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port block RAM between the CPU and the program loader.
// One transaction at a time: IDLE (arbitrate) -> ACCESS (RAM samples) -> RESP (capture).
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PRIO_MODE  = 0
) (
  input logic               clk,
  input logic               a_reset_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic                  winner_ldr_q, winner_ldr_d;
  logic                  last_ldr_q, last_ldr_d;
  logic                  mem_wen_q, mem_wen_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  cpu_gnt_q, cpu_gnt_d;
  logic                  ldr_gnt_q, ldr_gnt_d;
  logic                  cpu_done_q, cpu_done_d;
  logic                  ldr_done_q, ldr_done_d;
  logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_WIDTH-1:0] ldr_rdata_q, ldr_rdata_d;

  logic tie_ldr;
  logic pick_ldr;

  // Tie-break only; a lone request always wins. Unknown modes fall back to round-robin.
  always_comb begin
    case (PRIO_MODE)
      1:       tie_ldr = 1'b0;
      2:       tie_ldr = 1'b1;
      default: tie_ldr = ~last_ldr_q;
    endcase
  end

  assign pick_ldr = bus.ldr_req & (~bus.cpu_req | tie_ldr);

  always_comb begin
    state_d      = state_q;
    winner_ldr_d = winner_ldr_q;
    last_ldr_d   = last_ldr_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_gnt_d    = cpu_gnt_q;
    ldr_gnt_d    = ldr_gnt_q;
    cpu_done_d   = 1'b0;
    ldr_done_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    ldr_rdata_d  = ldr_rdata_q;

    case (state_q)
      StIdle: begin
        if (bus.cpu_req || bus.ldr_req) begin
          winner_ldr_d = pick_ldr;
          last_ldr_d   = pick_ldr;
          if (pick_ldr) begin
            mem_wen_d   = bus.ldr_wen;
            mem_addr_d  = bus.ldr_addr;
            mem_wdata_d = bus.ldr_wdata;
            ldr_gnt_d   = 1'b1;
          end else begin
            mem_wen_d   = bus.cpu_wen;
            mem_addr_d  = bus.cpu_addr;
            mem_wdata_d = bus.cpu_wdata;
            cpu_gnt_d   = 1'b1;
          end
          state_d = StAccess;
        end
      end
      StAccess: begin
        mem_wen_d = 1'b0;
        state_d   = StResp;
      end
      StResp: begin
        // Read data is captured for writes too, so rdata always reflects the last access.
        if (winner_ldr_q) begin
          ldr_rdata_d = bus.mem_rdata;
          ldr_gnt_d   = 1'b0;
          ldr_done_d  = 1'b1;
        end else begin
          cpu_rdata_d = bus.mem_rdata;
          cpu_gnt_d   = 1'b0;
          cpu_done_d  = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state_q      <= StIdle;
      winner_ldr_q <= 1'b0;
      last_ldr_q   <= 1'b1;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      ldr_gnt_q    <= 1'b0;
      cpu_done_q   <= 1'b0;
      ldr_done_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      winner_ldr_q <= winner_ldr_d;
      last_ldr_q   <= last_ldr_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_gnt_q    <= cpu_gnt_d;
      ldr_gnt_q    <= ldr_gnt_d;
      cpu_done_q   <= cpu_done_d;
      ldr_done_q   <= ldr_done_d;
      cpu_rdata_q  <= cpu_rdata_d;
      ldr_rdata_q  <= ldr_rdata_d;
    end
  end

  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cpu_gnt   = cpu_gnt_q;
  assign bus.ldr_gnt   = ldr_gnt_q;
  assign bus.cpu_done  = cpu_done_q;
  assign bus.ldr_done  = ldr_done_q;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: round-robin instance (bus0) and CPU-priority instance (bus1),
// each backed by a read-first synchronous RAM model.
module tb_mem_port_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst0_n;
  logic rst1_n;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIO_MODE(0)) u_dut0 (
    .clk       (clk),
    .a_reset_n (rst0_n),
    .bus       (bus0)
  );

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIO_MODE(1)) u_dut1 (
    .clk       (clk),
    .a_reset_n (rst1_n),
    .bus       (bus1)
  );

  logic [DW-1:0] ram0 [256];
  logic [DW-1:0] ram1 [256];

  always @(posedge clk) begin
    if (bus0.mem_wen) ram0[bus0.mem_addr] <= bus0.mem_wdata;
    bus0.mem_rdata <= ram0[bus0.mem_addr];
  end

  always @(posedge clk) begin
    if (bus1.mem_wen) ram1[bus1.mem_addr] <= bus1.mem_wdata;
    bus1.mem_rdata <= ram1[bus1.mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single CPU transaction on bus0; returns at cycle 4 with the arbiter idle.
  task automatic cpu_xfer0(input logic wen, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input bit chk_rd, input logic [DW-1:0] exp_rd);
    bus0.cpu_req   = 1'b1;
    bus0.cpu_wen   = wen;
    bus0.cpu_addr  = addr;
    bus0.cpu_wdata = wdata;
    tick();
    check("c1_cpu_gnt", bus0.cpu_gnt, 1);
    check("c1_mem_wen", bus0.mem_wen, wen);
    check("c1_mem_addr", bus0.mem_addr, addr);
    check("c1_busy", bus0.busy, 1);
    bus0.cpu_req = 1'b0;
    tick();
    check("c2_mem_wen", bus0.mem_wen, 0);
    check("c2_cpu_gnt", bus0.cpu_gnt, 1);
    check("c2_cpu_done", bus0.cpu_done, 0);
    tick();
    check("c3_cpu_done", bus0.cpu_done, 1);
    check("c3_cpu_gnt", bus0.cpu_gnt, 0);
    check("c3_busy", bus0.busy, 0);
    check("c3_ldr_gnt", bus0.ldr_gnt, 0);
    check("c3_ldr_done", bus0.ldr_done, 0);
    if (chk_rd) check("c3_cpu_rdata", bus0.cpu_rdata, exp_rd);
    tick();
    check("c4_cpu_done", bus0.cpu_done, 0);
  endtask

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    bus0.cpu_req = 1'b0; bus0.cpu_wen = 1'b0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
    bus0.ldr_req = 1'b0; bus0.ldr_wen = 1'b0; bus0.ldr_addr = '0; bus0.ldr_wdata = '0;
    bus1.cpu_req = 1'b0; bus1.cpu_wen = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.ldr_req = 1'b0; bus1.ldr_wen = 1'b0; bus1.ldr_addr = '0; bus1.ldr_wdata = '0;
    #1;
    check("rst_busy", bus0.busy, 0);
    check("rst_gnt", {bus0.cpu_gnt, bus0.ldr_gnt}, 0);
    check("rst_done", {bus0.cpu_done, bus0.ldr_done}, 0);
    check("rst_mem_wen", bus0.mem_wen, 0);
    check("rst_mem_addr", bus0.mem_addr, 0);
    check("rst_mem_wdata", bus0.mem_wdata, 0);
    check("rst_rdata", {bus0.cpu_rdata, bus0.ldr_rdata}, 0);
    tick();
    tick();
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    tick();

    // CPU write then read
    cpu_xfer0(1'b1, 8'h12, 16'hBEEF, 1'b0, 16'h0000);
    cpu_xfer0(1'b0, 8'h12, 16'h0000, 1'b1, 16'hBEEF);
    check("cpu_only_ldr_rdata", bus0.ldr_rdata, 0);

    // Loader back-to-back writes 0x00..0x03 = 0xA0..0xA3
    bus0.ldr_req = 1'b1; bus0.ldr_wen = 1'b1; bus0.ldr_addr = 8'h00; bus0.ldr_wdata = 16'h00A0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c % 3 == 1) begin
        check("b2b_ldr_gnt", bus0.ldr_gnt, 1);
        check("b2b_mem_wen", bus0.mem_wen, 1);
        check("b2b_mem_addr", bus0.mem_addr, (c - 1) / 3);
        check("b2b_mem_wdata", bus0.mem_wdata, 32'h00A0 + (c - 1) / 3);
        bus0.ldr_addr  = bus0.ldr_addr + 8'd1;
        bus0.ldr_wdata = bus0.ldr_wdata + 16'd1;
        if (c == 10) bus0.ldr_req = 1'b0;
      end
      if (c % 3 == 0) check("b2b_ldr_done", bus0.ldr_done, 1);
    end
    tick();
    check("b2b_end_busy", bus0.busy, 0);
    cpu_xfer0(1'b0, 8'h03, 16'h0000, 1'b1, 16'h00A3);

    // Write-data isolation: requester changes addr/data during ACCESS
    bus0.cpu_req = 1'b1; bus0.cpu_wen = 1'b1; bus0.cpu_addr = 8'h20; bus0.cpu_wdata = 16'h1234;
    tick();
    check("iso_gnt", bus0.cpu_gnt, 1);
    bus0.cpu_req = 1'b0; bus0.cpu_addr = 8'h21; bus0.cpu_wdata = 16'hFFFF;
    tick();
    check("iso_mem_addr", bus0.mem_addr, 8'h20);
    check("iso_mem_wdata", bus0.mem_wdata, 16'h1234);
    tick();
    tick();
    cpu_xfer0(1'b0, 8'h20, 16'h0000, 1'b1, 16'h1234);

    // Reset during ACCESS of a CPU write
    bus0.cpu_req = 1'b1; bus0.cpu_wen = 1'b1; bus0.cpu_addr = 8'h30; bus0.cpu_wdata = 16'h5555;
    tick();
    check("rma_gnt_before", bus0.cpu_gnt, 1);
    rst0_n = 1'b0;
    bus0.cpu_req = 1'b0;
    #1;
    check("rma_mem_wen", bus0.mem_wen, 0);
    check("rma_cpu_gnt", bus0.cpu_gnt, 0);
    check("rma_busy", bus0.busy, 0);
    check("rma_cpu_rdata", bus0.cpu_rdata, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rma_no_done", bus0.cpu_done, 0);
    end
    rst0_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rma_no_done_after", bus0.cpu_done, 0);
    end

    // Round-robin ties: CPU first after reset, then alternate
    bus0.cpu_req = 1'b1; bus0.cpu_wen = 1'b0; bus0.cpu_addr = 8'h01;
    bus0.ldr_req = 1'b1; bus0.ldr_wen = 1'b0; bus0.ldr_addr = 8'h02;
    for (int c = 1; c <= 12; c++) begin
      tick();
      check("rr_excl_gnt", bus0.cpu_gnt & bus0.ldr_gnt, 0);
      if (c % 3 == 1) begin
        check("rr_cpu_gnt", bus0.cpu_gnt, ((c - 1) / 3) % 2 == 0);
        check("rr_ldr_gnt", bus0.ldr_gnt, ((c - 1) / 3) % 2 == 1);
        check("rr_mem_addr", bus0.mem_addr, (((c - 1) / 3) % 2 == 0) ? 1 : 2);
        if (c == 10) begin
          bus0.cpu_req = 1'b0;
          bus0.ldr_req = 1'b0;
        end
      end
      if (c % 3 == 0) begin
        check("rr_cpu_done", bus0.cpu_done, (c / 3) % 2 == 1);
        check("rr_ldr_done", bus0.ldr_done, (c / 3) % 2 == 0);
      end
    end
    tick();
    check("rr_end_busy", bus0.busy, 0);

    // CPU fixed priority on bus1
    bus1.cpu_req = 1'b1; bus1.cpu_wen = 1'b0; bus1.cpu_addr = 8'h05;
    bus1.ldr_req = 1'b1; bus1.ldr_wen = 1'b0; bus1.ldr_addr = 8'h06;
    for (int c = 1; c <= 13; c++) begin
      tick();
      check("fp_excl_gnt", bus1.cpu_gnt & bus1.ldr_gnt, 0);
      if (c % 3 == 1 && c <= 10) begin
        check("fp_cpu_gnt", bus1.cpu_gnt, 1);
        check("fp_ldr_gnt", bus1.ldr_gnt, 0);
        if (c == 10) bus1.cpu_req = 1'b0;
      end
      if (c == 13) begin
        check("fp_ldr_after", bus1.ldr_gnt, 1);
        check("fp_cpu_after", bus1.cpu_gnt, 0);
        check("fp_ldr_addr", bus1.mem_addr, 8'h06);
        bus1.ldr_req = 1'b0;
      end
    end
    tick();
    tick();
    check("fp_ldr_done", bus1.ldr_done, 1);
    tick();
    check("fp_end_busy", bus1.busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the single-port instruction/data block RAM between the CPU controller and a program loader (debug/boot path).
- It accepts one transaction at a time, drives the RAM address, write-enable and write-data ports from registers, and returns read data with a completion pulse to the winning requester.
- It sits between the two requesters and the block RAM, replacing the direct address/data-register connection to the RAM port.

## Interface
Parameters:
- ADDR_WIDTH, 8, RAM address width
- DATA_WIDTH, 16, RAM data width
- PRIO_MODE, 0, arbitration mode: 0 = round-robin, 1 = CPU fixed priority, 2 = loader fixed priority

Ports:
- clk  in  1  system clock; all logic on its rising edge
- a_reset_n  in  1  reset, asynchronous and active-low
- cpu_req  in  1  CPU request, level
- cpu_wen  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_WIDTH  CPU address
- cpu_wdata  in  DATA_WIDTH  CPU write data
- cpu_gnt  out  1  CPU owns the RAM port
- cpu_done  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_WIDTH  captured read data
- ldr_req, ldr_wen, ldr_addr, ldr_wdata, ldr_gnt, ldr_done, ldr_rdata: loader equivalents, same widths and meaning
- mem_wen  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data; 1-cycle synchronous read
- busy  out  1  state is not IDLE

## Operation
- The FSM has three states:
  - IDLE: if either request is high, pick a winner, register its addr, wen and wdata onto the mem_* outputs, set the winner's gnt, and go to ACCESS.
  - ACCESS: the RAM samples the port on the closing edge; clear mem_wen on exit; go to RESP.
  - RESP: mem_rdata is valid. Load it into the winner's rdata register (reads and writes alike), clear gnt, pulse the winner's done for the next cycle, go to IDLE.
- Arbitration when only one request is high: that request wins.
- Arbitration when both requests are high:
  - PRIO_MODE 0: the requester not granted last wins. The last-grant pointer resets to "loader", so the CPU wins the first tie.
  - PRIO_MODE 1: the CPU always wins.
  - PRIO_MODE 2: the loader always wins.
- The last-grant pointer updates on every grant, in all modes.
- Requester contract:
  - addr, wen and wdata are sampled only on the IDLE→ACCESS edge and may change afterwards.
  - req still high during the done cycle is treated as a new request, so back-to-back transfers work.
- Illegal PRIO_MODE values behave as mode 0.
- Reset values:
  - state = IDLE, and busy is therefore 0.
  - All gnt and done outputs = 0.
  - mem_wen = 0, mem_addr = 0, mem_wdata = 0.
  - cpu_rdata = 0, ldr_rdata = 0.
  - Last-grant pointer = loader.
- Reset mid-transaction: outputs return to the reset values immediately. No done is issued and the aborted requester gets no completion.

## Timing
- Cycle 0: req is high in IDLE.
- Edge 0→1: mem_addr, mem_wen and mem_wdata are loaded; gnt goes high; busy goes high.
- Cycle 1 (ACCESS): the RAM port is driven; the write or read happens at edge 1→2.
- Cycle 2 (RESP): mem_rdata is valid.
- Edge 2→3: rdata is captured; gnt falls; done rises; state returns to IDLE.
- Cycle 3: done = 1 and rdata is valid. A new arbitration may occur in this same cycle.
- Latency: 3 cycles from req to done. Peak throughput: one access per 3 cycles.
- Per access:
  - mem_wen is high for exactly 1 cycle (cycle 1), and only for writes.
  - gnt is high for exactly cycles 1–2, and never on both requesters at once.
  - done lasts exactly one cycle.
- mem_addr and mem_wdata hold their last values in IDLE. Only mem_wen matters to the RAM.
- A requester's rdata holds until that requester's next completion.
- The other requester's gnt, done and rdata are unaffected by a transaction.

## Test plan
- CPU write then read: cpu writes addr 0x12 = 0xBEEF, then reads addr 0x12.
  - Required: mem_wen high for exactly 1 cycle.
  - Required: cpu_done at cycle 3 of each transaction.
  - Required: cpu_rdata = 0xBEEF after the read.
  - Required: ldr_* outputs stay 0.
- Simultaneous requests, PRIO_MODE 0, both req held high, cpu addr 0x01 and ldr addr 0x02:
  - Required: grants alternate CPU, LDR, CPU, LDR, with done every 3 cycles.
  - Required: mem_addr alternates 0x01, 0x02.
  - Required: cpu_gnt and ldr_gnt never both 1.
- Fixed priority, PRIO_MODE 1, both requests held for 4 transactions:
  - Required: 4 CPU grants in a row.
  - Required: after cpu_req drops, the loader is granted at the next IDLE.
- Back-to-back: ldr_req held through the done cycle, loader writes 0x00..0x03 with data 0xA0..0xA3.
  - Required: 4 transactions in 12 cycles.
  - Required: a CPU read of 0x03 returns 0xA3.
- Reset mid-access: a_reset_n goes low during ACCESS of a CPU write.
  - Required: mem_wen = 0, cpu_gnt = 0 and busy = 0 immediately.
  - Required: no cpu_done occurs.
  - Required: after release, the first tie goes to the CPU.
- Write-data isolation: cpu_addr and cpu_wdata change during ACCESS.
  - Required: mem_addr and mem_wdata keep the values sampled at grant.
  - Required: the RAM content matches the sampled values.
